clstm_load_scheduler: RTL
=========================

Name: clstm_load_scheduler

Overview:
Sequencing controller for the C-LSTM datapath. On command it streams the weight-buffer write enables for stage1, stage2 and stage3 one bank at a time, with a shared word address. It then runs one sequence of N_STEPS input vectors through the datapath using the i_valid/i_ready handshake, and counts o_valid results until the sequence completes. It sits between the top-level test harness and the datapath; the weight and X data themselves come from the random generators.

Parameters:
N_S1, 8, stage1 bank count (width of wen_stage1)
N_S2, 7, stage2 bank count (width of wen_stage2)
N_S3, 2, stage3 bank count (width of wen_stage3)
WORDS, 16, words written per bank (power of 2, >=2)
N_STEPS, 64, input vectors per sequence (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
cfg_start  in  1  pulse: start weight load (honoured in IDLE/READY only)
seq_start  in  1  pulse: start a sequence (honoured in READY only)
wen_stage1  out  N_S1  one-hot stage1 bank write enable
wen_stage2  out  N_S2  one-hot stage2 bank write enable
wen_stage3  out  N_S3  one-hot stage3 bank write enable
w_addr  out  $clog2(WORDS)  word address for the active write enable
start_compute  out  1  one-cycle pulse on entry to RUN
i_valid  out  1  input vector valid to datapath
i_ready  in  1  datapath accepts input
o_valid  in  1  datapath result valid
loaded  out  1  weights resident
busy  out  1  state is LOAD1/LOAD2/LOAD3/RUN/DRAIN
done  out  1  one-cycle pulse at sequence completion
issued  out  $clog2(N_STEPS+1)  accepted inputs in current sequence
received  out  $clog2(N_STEPS+1)  o_valid beats in current sequence
err  out  1  sticky: o_valid seen outside RUN/DRAIN, or received would exceed N_STEPS

Behaviour:
- All outputs are registered. When rst is low at a clock edge: state=IDLE and every output is 0 (wen_*, w_addr, start_compute, i_valid, loaded, busy, done, issued, received, err). Reset takes effect mid-operation with no completion of a load or sequence.
- States: IDLE, LOAD1, LOAD2, LOAD3, READY, RUN, DRAIN, DONE.
- IDLE: cfg_start -> LOAD1. seq_start is ignored.
- LOADk: one write per cycle. The first write appears in the cycle after cfg_start is sampled.
  - Bank index b starts at 0 and w_addr starts at 0. wen_stagek = 1<<b.
  - w_addr increments every cycle. When it wraps from WORDS-1 to 0, b increments.
  - After bank N_Sk-1, word WORDS-1, move to the next LOAD state (LOAD3 -> READY). There is no idle cycle between stages.
  - Total load = (N_S1+N_S2+N_S3)*WORDS cycles = 272 at defaults.
  - Only one wen bit across all three buses is ever high. wen_* are 0 outside LOAD states.
- READY: loaded=1. cfg_start -> LOAD1 (reload, loaded stays 1). seq_start -> RUN. If both are asserted, cfg_start wins.
- RUN:
  - On entry, start_compute=1 for exactly one cycle; issued and received are cleared to 0.
  - i_valid=1 while issued<N_STEPS.
  - issued increments on each cycle where i_valid&&i_ready.
  - i_valid holds under backpressure.
  - When issued reaches N_STEPS, i_valid drops in the same cycle the register updates, and the state goes to DRAIN.
- RUN/DRAIN: received increments on o_valid. DRAIN -> DONE when received==N_STEPS, including the case where the final o_valid coincides with the final handshake.
- DONE: done=1 for one cycle, then READY. loaded is retained; issued and received hold their values until the next RUN entry.
- cfg_start and seq_start are ignored in LOAD*, RUN, DRAIN and DONE.
- err:
  - Set by o_valid in IDLE, LOAD*, READY or DONE.
  - Set by o_valid when received==N_STEPS; in that case received saturates.
  - Cleared only by reset.
- busy=1 exactly in LOAD1/LOAD2/LOAD3/RUN/DRAIN.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0, state IDLE. seq_start in IDLE -> no start_compute, i_valid stays 0.
- Weight load: cfg_start at cycle 0 ->
  - cycles 1..16: wen_stage1=8'h01, w_addr 0..15; cycle 17: 8'h02.
  - cycles 129..240: wen_stage2 walking 7'h01..7'h40.
  - cycles 241..272: wen_stage3 2'b01 then 2'b10.
  - cycle 273: loaded=1, busy=0. Exactly 272 write cycles, one-hot at every cycle.
- Sequence, no backpressure, i_ready=1, o_valid=i_valid delayed 3 cycles ->
  - start_compute pulse, then 64 consecutive i_valid cycles.
  - issued=64, received=64.
  - done pulse 3 cycles after the last handshake, then back to READY.
- Backpressure: i_ready toggles 1,0,0,1 repeating -> i_valid never drops before issued=64, 64 handshakes total, no duplicate counts, done=1 once.
- Reload and priority: cfg_start and seq_start together in READY -> LOAD1 entered, no start_compute. seq_start during LOAD2 is ignored.
- Errors and mid-op reset:
  - o_valid pulse in READY -> err=1 and stays 1 through a later clean sequence.
  - A 65th o_valid -> err=1, received=64.
  - rst=0 at issued=20 -> IDLE, loaded=0, i_valid=0 next cycle.

Source files
------------

// File: rtl/clstm_load_scheduler.sv
// ============================================================================
//  Module   : clstm_load_scheduler
//  Purpose  : Streams stage1/2/3 weight-bank write enables, then runs one
//             handshaked input sequence through the C-LSTM datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clstm_load_scheduler #(
  parameter int N_S1    = 8,
  parameter int N_S2    = 7,
  parameter int N_S3    = 2,
  parameter int WORDS   = 16,
  parameter int N_STEPS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         seq_start,
  output logic [N_S1-1:0]              wen_stage1,
  output logic [N_S2-1:0]              wen_stage2,
  output logic [N_S3-1:0]              wen_stage3,
  output logic [$clog2(WORDS)-1:0]     w_addr,
  output logic                         start_compute,
  output logic                         i_valid,
  input  logic                         i_ready,
  input  logic                         o_valid,
  output logic                         loaded,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_STEPS+1)-1:0] issued,
  output logic [$clog2(N_STEPS+1)-1:0] received,
  output logic                         err
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(N_STEPS + 1);
  localparam logic [AW-1:0] c_last_word = AW'(WORDS - 1);
  localparam logic [CW-1:0] c_n_steps   = CW'(N_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_LOAD3 = 3'd3,
    S_READY = 3'd4,
    S_RUN   = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t r_state;

  logic          w_last_word;
  logic          w_hs;
  logic          w_rx_phase;
  logic          w_rx_overflow;
  logic          w_stray_ovalid;
  logic [CW-1:0] w_issued_next;
  logic [CW-1:0] w_received_next;

  always_comb begin
    w_last_word     = (w_addr == c_last_word);
    w_hs            = i_valid && i_ready;
    w_issued_next   = issued + CW'(w_hs);
    w_rx_phase      = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_rx_overflow   = w_rx_phase && o_valid && (received == c_n_steps);
    w_stray_ovalid  = !w_rx_phase && o_valid;
    // received saturates at N_STEPS; the extra beat only raises err
    w_received_next = received;
    if (w_rx_phase && o_valid && (received != c_n_steps))
      w_received_next = received + CW'(1);
  end

  // Bank selection walks the one-hot enable itself; its top bit marks the last bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      wen_stage1    <= '0;
      wen_stage2    <= '0;
      wen_stage3    <= '0;
      w_addr        <= '0;
      start_compute <= 1'b0;
      i_valid       <= 1'b0;
      loaded        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      issued        <= '0;
      received      <= '0;
      err           <= 1'b0;
    end else begin
      start_compute <= 1'b0;
      done          <= 1'b0;
      if (w_stray_ovalid || w_rx_overflow)
        err <= 1'b1;

      case (r_state)
        S_IDLE, S_READY: begin
          if (cfg_start) begin
            r_state    <= S_LOAD1;
            wen_stage1 <= N_S1'(1);
            w_addr     <= '0;
            busy       <= 1'b1;
          end else if (seq_start && (r_state == S_READY)) begin
            r_state       <= S_RUN;
            start_compute <= 1'b1;
            i_valid       <= 1'b1;
            issued        <= '0;
            received      <= '0;
            busy          <= 1'b1;
          end
        end
        S_LOAD1: begin
          w_addr <= w_addr + AW'(1);
          if (w_last_word) begin
            if (wen_stage1[N_S1-1]) begin
              wen_stage1 <= '0;
              wen_stage2 <= N_S2'(1);
              r_state    <= S_LOAD2;
            end else begin
              wen_stage1 <= wen_stage1 << 1;
            end
          end
        end
        S_LOAD2: begin
          w_addr <= w_addr + AW'(1);
          if (w_last_word) begin
            if (wen_stage2[N_S2-1]) begin
              wen_stage2 <= '0;
              wen_stage3 <= N_S3'(1);
              r_state    <= S_LOAD3;
            end else begin
              wen_stage2 <= wen_stage2 << 1;
            end
          end
        end
        S_LOAD3: begin
          w_addr <= w_addr + AW'(1);
          if (w_last_word) begin
            if (wen_stage3[N_S3-1]) begin
              wen_stage3 <= '0;
              r_state    <= S_READY;
              loaded     <= 1'b1;
              busy       <= 1'b0;
            end else begin
              wen_stage3 <= wen_stage3 << 1;
            end
          end
        end
        S_RUN: begin
          issued   <= w_issued_next;
          received <= w_received_next;
          if (w_hs && (w_issued_next == c_n_steps)) begin
            i_valid <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          received <= w_received_next;
          if (w_received_next == c_n_steps) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_READY;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
